instr_fetch_unit_multispec: RTL and testbench
=============================================

// Module: instr_fetch_unit_multispec
// PURPOSE
//  Next-generation fetch unit: drives the PC to instruction memory, predecodes jumps/branches, and writes fetched words to the instruction queue.
//  Supports up to SPEC_DEPTH unresolved branches in flight (predecessor: one), using an in-order checkpoint FIFO of recovery PCs.
//  Branch resolution is oldest-first. A misprediction redirects to the oldest checkpoint's recovery PC, drops all checkpoints, and pulses flush_o.
//  Sits between instruction memory, branch predictor, branch ALU and instruction queue.
// PARAMETERS
//  IMM_WIDTH   12  width of br_imm_o, encoding {instr[31:27], instr[16:10]}
//  SPEC_DEPTH  4   max unresolved branches, >=1
//  TAG_WIDTH   $clog2(SPEC_DEPTH) (min 1)  width of branch tag
//  RESET_PC    32'h0  PC value loaded on reset
// PORTS
//  clk_i                       in   1          system clock
//  reset_ni                    in   1          synchronous, active-low reset
//  program_counter_branched_i  in   32         predicted taken target for current instr
//  br_taken_i                  in   1          prediction for current branch
//  br_imm_o                    out  IMM_WIDTH  branch immediate to predictor
//  issuing_branch_o            out  1          branch written to IQ this cycle
//  br_tag_o                    out  TAG_WIDTH  checkpoint slot of issued branch
//  cond_eval_i                 in   1          branch ALU resolved oldest branch
//  corr_pred_i                 in   1          resolved prediction was correct
//  flush_o                     out  1          mispredict: downstream squashes younger ops
//  spec_count_o                out  TAG_WIDTH+1  unresolved branches
//  spurious_resolve_o          out  1          cond_eval_i with spec_count_o==0
//  iq_full_i                   in   1          instruction queue full
//  iq_write_o                  out  1          write fetched_instr_o to IQ
//  fetched_instr_o             out  32         = instr_i
//  instr_i                     in   32         instruction at program_counter_o
//  program_counter_o           out  32         fetch PC, registered
// BEHAVIOUR
//  Reset: a clock edge with reset_ni=0 sets program_counter_o=RESET_PC and spec_count_o=0, and clears the FIFO pointers.
//   Reset mid-speculation discards all checkpoints.
//  Combinational outputs are 0 whenever their conditions are false.
//  Predecode: opcode instr_i[6:0]. BR=7'b1100011, JMP=7'b1100111.
//   Jump target = PC + sext32({instr_i[31:7],2'b00}).
//   All PC arithmetic is mod 2^32; wrap-around is legal.
//  Priority per cycle, highest first:
//   1 Mispredict (cond_eval_i & ~corr_pred_i & count>0):
//     next PC = recovery PC of oldest checkpoint; count<=0; FIFO emptied; flush_o=1.
//     iq_write_o=0 and issuing_branch_o=0 that cycle.
//   2 iq_full_i: PC holds; no IQ write; no jump taken.
//   3 Branch: issues only if slot_free = (count<SPEC_DEPTH) | (cond_eval_i & corr_pred_i).
//     On issue: iq_write_o=1, issuing_branch_o=1, br_tag_o = write pointer, checkpoint pushed.
//     Next PC = br_taken_i ? program_counter_branched_i : PC+4.
//     Recovery PC = br_taken_i ? PC+4 : program_counter_branched_i.
//     If no slot is free: stall, PC holds, no write.
//   4 Jump: next PC = jump target; not written to IQ.
//   5 Other: iq_write_o=1; next PC = PC+4.
//  Correct resolve (cond_eval_i & corr_pred_i & count>0): pop oldest checkpoint.
//   Simultaneous pop and push leaves count unchanged; pointers wrap mod SPEC_DEPTH.
//  Resolve with count==0: ignored, spurious_resolve_o=1 for that cycle only.
//  Latency: PC update 1 cycle. IQ write/flush are combinational in the current cycle.
// STRUCTURE
//  Package data_types: word32_t (existing), plus new BR_OPCODE, JMP_OPCODE, fetch_ckpt_t {word32_t recovery_pc}.
//  Sub-module spec_checkpoint_fifo #(DEPTH, type T): push, pop, clear, count, wr_ptr, head.
//   Clear has priority over push/pop.
//  Top level holds predecode, priority logic and PC register.
// TESTING
//  1 Reset: reset_ni=0 for 2 cycles mid-run with count=3 -> PC=RESET_PC, spec_count_o=0.
//  2 Straight-line ALU ops from PC 0 -> PC 0,4,8,C; iq_write_o=1 each cycle.
//    iq_full_i for 2 cycles -> PC holds, no writes.
//  3 SPEC_DEPTH=4: five BR at PCs 0x10..0x20, taken targets 0x100+; resolves only after all issue ->
//    four issue with tags 0,1,2,3; fifth stalls until a correct resolve, then issues in the same cycle with tag 0.
//  4 Two branches in flight: 0x10 predicted taken to 0x80, then 0x80 predicted not-taken, target 0x200.
//    Resolve first as mispredict -> flush_o=1, next PC=0x14, spec_count_o=0.
//  5 Jump at 0x40, imm field = -4 -> next PC=0x30, no IQ write.
//    Jump at 0xFFFFFFFC with imm 1 -> PC wraps to 0x0.
//  6 cond_eval_i=1 with count==0 -> spurious_resolve_o=1; PC advances normally.
//    Mispredict while iq_full_i=1 -> redirect still happens.

Source files
------------

// File: rtl/instr_fetch_unit_multispec_pkg.sv
// Shared types and constants for the multi-speculation fetch unit.
package instr_fetch_unit_multispec_pkg;

  typedef logic [31:0] word32_t;

  localparam logic [6:0] BR_OPCODE  = 7'b1100011;
  localparam logic [6:0] JMP_OPCODE = 7'b1100111;

  typedef struct packed {
    word32_t recovery_pc;
  } fetch_ckpt_t;

  // Jump offset: instr[31:7] is a word offset, sign-extended to 32 bits.
  function automatic word32_t jump_offset(word32_t instr);
    return {{5{instr[31]}}, instr[31:7], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_multispec_if.sv
// Fetch-unit bus: instruction memory, predictor, branch ALU and instruction queue signals.
interface instr_fetch_unit_multispec_if
  import instr_fetch_unit_multispec_pkg::*;
#(
  parameter int unsigned IMM_WIDTH = 12,
  parameter int unsigned TAG_WIDTH = 2
) ();

  word32_t              program_counter_branched_i;
  logic                 br_taken_i;
  logic [IMM_WIDTH-1:0] br_imm_o;
  logic                 issuing_branch_o;
  logic [TAG_WIDTH-1:0] br_tag_o;
  logic                 cond_eval_i;
  logic                 corr_pred_i;
  logic                 flush_o;
  logic [TAG_WIDTH:0]   spec_count_o;
  logic                 spurious_resolve_o;
  logic                 iq_full_i;
  logic                 iq_write_o;
  word32_t              fetched_instr_o;
  word32_t              instr_i;
  word32_t              program_counter_o;

  modport master (
    input  program_counter_branched_i, br_taken_i, cond_eval_i, corr_pred_i, iq_full_i,
           instr_i,
    output br_imm_o, issuing_branch_o, br_tag_o, flush_o, spec_count_o, spurious_resolve_o,
           iq_write_o, fetched_instr_o, program_counter_o
  );

  modport slave (
    output program_counter_branched_i, br_taken_i, cond_eval_i, corr_pred_i, iq_full_i,
           instr_i,
    input  br_imm_o, issuing_branch_o, br_tag_o, flush_o, spec_count_o, spurious_resolve_o,
           iq_write_o, fetched_instr_o, program_counter_o
  );

endinterface

// File: rtl/spec_checkpoint_fifo.sv
// In-order checkpoint FIFO for unresolved branches; clear wins over push/pop.
module spec_checkpoint_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0],
  parameter int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  T                data_i,
  output T                head_o,
  output logic [PtrW:0]   count_o,
  output logic [PtrW-1:0] wr_ptr_o
);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/instr_fetch_unit_multispec.sv
// Fetch unit with predecode, multi-branch speculation and misprediction recovery.
module instr_fetch_unit_multispec
  import instr_fetch_unit_multispec_pkg::*;
#(
  parameter int unsigned IMM_WIDTH  = 12,
  parameter int unsigned SPEC_DEPTH = 4,
  parameter int unsigned TAG_WIDTH  = (SPEC_DEPTH > 1) ? $clog2(SPEC_DEPTH) : 1,
  parameter word32_t     RESET_PC   = 32'h0
) (
  input logic                          clk_i,
  input logic                          reset_ni,
  instr_fetch_unit_multispec_if.master fetch_io
);

  localparam logic [TAG_WIDTH:0] DepthCnt = (TAG_WIDTH + 1)'(SPEC_DEPTH);

  word32_t              pc_q, pc_d;
  word32_t              pc_plus4;
  word32_t              instr;
  logic                 is_br, is_jmp;
  logic                 has_ckpt, mispredict, resolve_ok, slot_free;
  logic                 push, iq_write, issuing, flush;
  logic [11:0]          imm_raw;
  logic [TAG_WIDTH:0]   count;
  logic [TAG_WIDTH-1:0] wr_ptr;
  fetch_ckpt_t          ckpt_new, ckpt_head;

  assign instr    = fetch_io.instr_i;
  assign pc_plus4 = pc_q + 32'd4;
  assign is_br    = (instr[6:0] == BR_OPCODE);
  assign is_jmp   = (instr[6:0] == JMP_OPCODE);
  assign imm_raw  = {instr[31:27], instr[16:10]};

  assign has_ckpt   = (count != '0);
  assign mispredict = fetch_io.cond_eval_i & ~fetch_io.corr_pred_i & has_ckpt;
  assign resolve_ok = fetch_io.cond_eval_i & fetch_io.corr_pred_i & has_ckpt;
  // A correct resolve this cycle frees the oldest slot in time for a new push.
  assign slot_free  = (count < DepthCnt) | (fetch_io.cond_eval_i & fetch_io.corr_pred_i);

  assign ckpt_new.recovery_pc = fetch_io.br_taken_i ? pc_plus4
                                                    : fetch_io.program_counter_branched_i;

  spec_checkpoint_fifo #(
    .DEPTH (SPEC_DEPTH),
    .T     (fetch_ckpt_t),
    .PtrW  (TAG_WIDTH)
  ) u_ckpt_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .pop_i    (resolve_ok),
    .clear_i  (mispredict),
    .data_i   (ckpt_new),
    .head_o   (ckpt_head),
    .count_o  (count),
    .wr_ptr_o (wr_ptr)
  );

  always_comb begin
    pc_d     = pc_q;
    iq_write = 1'b0;
    issuing  = 1'b0;
    flush    = 1'b0;
    push     = 1'b0;
    if (mispredict) begin
      pc_d  = ckpt_head.recovery_pc;
      flush = 1'b1;
    end else if (fetch_io.iq_full_i) begin
      pc_d = pc_q;
    end else if (is_br) begin
      if (slot_free) begin
        iq_write = 1'b1;
        issuing  = 1'b1;
        push     = 1'b1;
        pc_d     = fetch_io.br_taken_i ? fetch_io.program_counter_branched_i : pc_plus4;
      end
    end else if (is_jmp) begin
      pc_d = pc_q + jump_offset(instr);
    end else begin
      iq_write = 1'b1;
      pc_d     = pc_plus4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) pc_q <= RESET_PC;
    else           pc_q <= pc_d;
  end

  assign fetch_io.br_imm_o           = is_br ? IMM_WIDTH'(imm_raw) : '0;
  assign fetch_io.issuing_branch_o   = issuing;
  assign fetch_io.br_tag_o           = issuing ? wr_ptr : '0;
  assign fetch_io.flush_o            = flush;
  assign fetch_io.spec_count_o       = count;
  assign fetch_io.spurious_resolve_o = fetch_io.cond_eval_i & ~has_ckpt;
  assign fetch_io.iq_write_o         = iq_write;
  assign fetch_io.fetched_instr_o    = instr;
  assign fetch_io.program_counter_o  = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit_multispec.sv
// Directed bench for instr_fetch_unit_multispec with hand-computed expectations.
module tb_instr_fetch_unit_multispec;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BR  = 32'h0000_0063;
  localparam logic [6:0]  JMP = 7'b1100111;

  logic clk;
  logic reset_ni;
  int   n_tests;
  int   n_fail;

  instr_fetch_unit_multispec_if #(.IMM_WIDTH(12), .TAG_WIDTH(2)) fetch_if ();

  instr_fetch_unit_multispec #(
    .IMM_WIDTH  (12),
    .SPEC_DEPTH (4),
    .TAG_WIDTH  (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .fetch_io (fetch_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fetch_if.instr_i                    = NOP;
    fetch_if.br_taken_i                 = 1'b0;
    fetch_if.program_counter_branched_i = 32'h0;
    fetch_if.cond_eval_i                = 1'b0;
    fetch_if.corr_pred_i                = 1'b0;
    fetch_if.iq_full_i                  = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset_ni = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 00000000", fetch_if.program_counter_o);
    end
    n_tests++;
    if (fetch_if.spec_count_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_if.spec_count_o);
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (fetch_if.program_counter_o !== 32'(4 * i) || fetch_if.iq_write_o !== 1'b1) begin
        n_fail++;
        $display("FAIL straight_%0d: pc %h wr %b want pc %h wr 1", i,
                 fetch_if.program_counter_o, fetch_if.iq_write_o, 32'(4 * i));
      end
      tick();
    end
    fetch_if.iq_full_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (fetch_if.iq_write_o !== 1'b0) begin
        n_fail++; $display("FAIL iq_full_write_%0d: got %b want 0", i, fetch_if.iq_write_o);
      end
      tick();
      n_tests++;
      if (fetch_if.program_counter_o !== 32'h10) begin
        n_fail++; $display("FAIL iq_full_pc_%0d: got %h want 00000010", i,
                           fetch_if.program_counter_o);
      end
    end
    fetch_if.iq_full_i = 1'b0;
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h14) begin
      n_fail++; $display("FAIL iq_release_pc: got %h want 00000014", fetch_if.program_counter_o);
    end
  endtask

  task automatic test_spec_depth();
    do_reset();
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      fetch_if.instr_i                    = BR;
      fetch_if.br_taken_i                 = 1'b0;
      fetch_if.program_counter_branched_i = 32'h100 + 32'(4 * k);
      #1;
      n_tests++;
      if (fetch_if.issuing_branch_o !== 1'b1 || fetch_if.br_tag_o !== 2'(k)) begin
        n_fail++; $display("FAIL depth_issue_%0d: issue %b tag %0d want 1 tag %0d", k,
                           fetch_if.issuing_branch_o, fetch_if.br_tag_o, k);
      end
      tick();
      n_tests++;
      if (fetch_if.spec_count_o !== 3'(k + 1) ||
          fetch_if.program_counter_o !== 32'h14 + 32'(4 * k)) begin
        n_fail++; $display("FAIL depth_state_%0d: count %0d pc %h want %0d pc %h", k,
                           fetch_if.spec_count_o, fetch_if.program_counter_o, k + 1,
                           32'h14 + 32'(4 * k));
      end
    end
    fetch_if.program_counter_branched_i = 32'h110;
    #1;
    n_tests++;
    if (fetch_if.issuing_branch_o !== 1'b0 || fetch_if.iq_write_o !== 1'b0) begin
      n_fail++; $display("FAIL depth_stall: issue %b wr %b want 0 0",
                         fetch_if.issuing_branch_o, fetch_if.iq_write_o);
    end
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h20 || fetch_if.spec_count_o !== 3'd4) begin
      n_fail++; $display("FAIL depth_stall_state: pc %h count %0d want 00000020 4",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    fetch_if.cond_eval_i = 1'b1;
    fetch_if.corr_pred_i = 1'b1;
    #1;
    n_tests++;
    if (fetch_if.issuing_branch_o !== 1'b1 || fetch_if.br_tag_o !== 2'd0) begin
      n_fail++; $display("FAIL depth_fifth_issue: issue %b tag %0d want 1 tag 0",
                         fetch_if.issuing_branch_o, fetch_if.br_tag_o);
    end
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h24 || fetch_if.spec_count_o !== 3'd4) begin
      n_fail++; $display("FAIL depth_fifth_state: pc %h count %0d want 00000024 4",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    // Oldest remaining checkpoint belongs to the branch at 0x14, recovery 0x104.
    fetch_if.instr_i     = NOP;
    fetch_if.corr_pred_i = 1'b0;
    #1;
    n_tests++;
    if (fetch_if.flush_o !== 1'b1 || fetch_if.iq_write_o !== 1'b0) begin
      n_fail++; $display("FAIL depth_flush: flush %b wr %b want 1 0",
                         fetch_if.flush_o, fetch_if.iq_write_o);
    end
    tick();
    set_idle();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h104 || fetch_if.spec_count_o !== 3'd0) begin
      n_fail++; $display("FAIL depth_recover: pc %h count %0d want 00000104 0",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
  endtask

  task automatic test_mispredict();
    logic [31:0] b;
    do_reset();
    repeat (4) tick();
    b        = BR;
    b[31:27] = 5'b10101;
    b[16:10] = 7'b1100110;
    fetch_if.instr_i                    = b;
    fetch_if.br_taken_i                 = 1'b1;
    fetch_if.program_counter_branched_i = 32'h80;
    #1;
    n_tests++;
    if (fetch_if.br_imm_o !== 12'hAE6 || fetch_if.issuing_branch_o !== 1'b1) begin
      n_fail++; $display("FAIL mp_first_issue: imm %h issue %b want AE6 1",
                         fetch_if.br_imm_o, fetch_if.issuing_branch_o);
    end
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h80 || fetch_if.spec_count_o !== 3'd1) begin
      n_fail++; $display("FAIL mp_first_state: pc %h count %0d want 00000080 1",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    fetch_if.instr_i                    = BR;
    fetch_if.br_taken_i                 = 1'b0;
    fetch_if.program_counter_branched_i = 32'h200;
    #1;
    n_tests++;
    if (fetch_if.br_tag_o !== 2'd1) begin
      n_fail++; $display("FAIL mp_second_tag: got %0d want 1", fetch_if.br_tag_o);
    end
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h84 || fetch_if.spec_count_o !== 3'd2) begin
      n_fail++; $display("FAIL mp_second_state: pc %h count %0d want 00000084 2",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    fetch_if.cond_eval_i = 1'b1;
    fetch_if.corr_pred_i = 1'b0;
    #1;
    n_tests++;
    if (fetch_if.flush_o !== 1'b1 || fetch_if.issuing_branch_o !== 1'b0 ||
        fetch_if.iq_write_o !== 1'b0) begin
      n_fail++; $display("FAIL mp_flush: flush %b issue %b wr %b want 1 0 0",
                         fetch_if.flush_o, fetch_if.issuing_branch_o, fetch_if.iq_write_o);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h14 || fetch_if.spec_count_o !== 3'd0) begin
      n_fail++; $display("FAIL mp_recover: pc %h count %0d want 00000014 0",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    n_tests++;
    if (fetch_if.flush_o !== 1'b0 || fetch_if.br_imm_o !== 12'h0) begin
      n_fail++; $display("FAIL mp_idle_outputs: flush %b imm %h want 0 000",
                         fetch_if.flush_o, fetch_if.br_imm_o);
    end
  endtask

  task automatic test_jump();
    do_reset();
    repeat (16) tick();
    fetch_if.instr_i = {25'h1FF_FFFC, JMP};
    #1;
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h40 || fetch_if.iq_write_o !== 1'b0) begin
      n_fail++; $display("FAIL jmp_at_40: pc %h wr %b want 00000040 0",
                         fetch_if.program_counter_o, fetch_if.iq_write_o);
    end
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h30) begin
      n_fail++; $display("FAIL jmp_back: got %h want 00000030", fetch_if.program_counter_o);
    end
    fetch_if.instr_i = {25'h1FF_FFF3, JMP};
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL jmp_to_top: got %h want fffffffc", fetch_if.program_counter_o);
    end
    fetch_if.instr_i = {25'd1, JMP};
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h0) begin
      n_fail++; $display("FAIL jmp_wrap: got %h want 00000000", fetch_if.program_counter_o);
    end
    set_idle();
  endtask

  task automatic test_spurious();
    do_reset();
    fetch_if.cond_eval_i = 1'b1;
    fetch_if.corr_pred_i = 1'b1;
    #1;
    n_tests++;
    if (fetch_if.spurious_resolve_o !== 1'b1 || fetch_if.iq_write_o !== 1'b1) begin
      n_fail++; $display("FAIL spurious_flag: spur %b wr %b want 1 1",
                         fetch_if.spurious_resolve_o, fetch_if.iq_write_o);
    end
    tick();
    fetch_if.cond_eval_i = 1'b0;
    #1;
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h4 || fetch_if.spec_count_o !== 3'd0 ||
        fetch_if.spurious_resolve_o !== 1'b0) begin
      n_fail++; $display("FAIL spurious_after: pc %h count %0d spur %b want 00000004 0 0",
                         fetch_if.program_counter_o, fetch_if.spec_count_o,
                         fetch_if.spurious_resolve_o);
    end
    set_idle();
  endtask

  task automatic test_mispredict_iq_full();
    do_reset();
    fetch_if.instr_i                    = BR;
    fetch_if.br_taken_i                 = 1'b1;
    fetch_if.program_counter_branched_i = 32'h50;
    tick();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h50) begin
      n_fail++; $display("FAIL mpf_taken: got %h want 00000050", fetch_if.program_counter_o);
    end
    set_idle();
    fetch_if.iq_full_i   = 1'b1;
    fetch_if.cond_eval_i = 1'b1;
    #1;
    n_tests++;
    if (fetch_if.flush_o !== 1'b1) begin
      n_fail++; $display("FAIL mpf_flush: got %b want 1", fetch_if.flush_o);
    end
    tick();
    set_idle();
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h4 || fetch_if.spec_count_o !== 3'd0) begin
      n_fail++; $display("FAIL mpf_recover: pc %h count %0d want 00000004 0",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
  endtask

  task automatic test_reset_mid_spec();
    do_reset();
    fetch_if.instr_i                    = BR;
    fetch_if.program_counter_branched_i = 32'h300;
    repeat (3) tick();
    n_tests++;
    if (fetch_if.spec_count_o !== 3'd3 || fetch_if.program_counter_o !== 32'hC) begin
      n_fail++; $display("FAIL rst_mid_setup: count %0d pc %h want 3 0000000c",
                         fetch_if.spec_count_o, fetch_if.program_counter_o);
    end
    set_idle();
    reset_ni = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
    #1;
    n_tests++;
    if (fetch_if.program_counter_o !== 32'h0 || fetch_if.spec_count_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_state: pc %h count %0d want 00000000 0",
                         fetch_if.program_counter_o, fetch_if.spec_count_o);
    end
    fetch_if.cond_eval_i = 1'b1;
    fetch_if.corr_pred_i = 1'b1;
    #1;
    n_tests++;
    if (fetch_if.spurious_resolve_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_empty: spur %b want 1", fetch_if.spurious_resolve_o);
    end
    tick();
    set_idle();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset_ni = 1'b0;
    set_idle();
    test_reset();
    test_straight_line();
    test_spec_depth();
    test_mispredict();
    test_jump();
    test_spurious();
    test_mispredict_iq_full();
    test_reset_mid_spec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
